// File: rtl/maze_solver_if.sv
// Maze solver bus: groups the start/maze/coordinate request signals and the
// walk status outputs of maze_solver into one bundle.
//   master : drives start, maze_data, start_x/y, goal_x/y; observes status
//   slave  : the solver; observes the request, drives busy/done/found,
//            curr_x/y, heading, step_count and path_data
interface maze_solver_if #(
  parameter int unsigned STEP_W = 10
);
  logic              start;
  logic [255:0]      maze_data;
  logic [3:0]        start_x;
  logic [3:0]        start_y;
  logic [3:0]        goal_x;
  logic [3:0]        goal_y;
  logic              busy;
  logic              done;
  logic              found;
  logic [3:0]        curr_x;
  logic [3:0]        curr_y;
  logic [1:0]        heading;
  logic [STEP_W-1:0] step_count;
  logic [255:0]      path_data;

  modport master (
    output start, maze_data, start_x, start_y, goal_x, goal_y,
    input  busy, done, found, curr_x, curr_y, heading, step_count, path_data
  );

  modport slave (
    input  start, maze_data, start_x, start_y, goal_x, goal_y,
    output busy, done, found, curr_x, curr_y, heading, step_count, path_data
  );
endinterface

// File: rtl/maze_solver.sv
// Right-hand wall follower over a 16x16 maze bitmap (bit x+16*y, 1 = open).
// A start pulse snapshots the maze and the start/goal cells, then the solver
// moves one cell per clock until it reaches the goal, runs out of moves,
// gets boxed in, or exhausts the MAX_STEPS budget.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : maze_solver_if slave modport
//            in : start, maze_data, start_x/y, goal_x/y
//            out: busy, done, found, curr_x/y, heading, step_count, path_data
// Heading encoding: 0=N(y-1), 1=E(x+1), 2=S(y+1), 3=W(x-1).
module maze_solver #(
  parameter int unsigned MAX_STEPS     = 1023,
  parameter int unsigned STEP_W        = 10,
  parameter logic [1:0]  START_HEADING = 2'd1
) (
  input logic          clk,
  input logic          rst_n,
  maze_solver_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    WALK,
    DONE
  } state_t;

  localparam logic [STEP_W-1:0] MAX_CNT = STEP_W'(MAX_STEPS);

  // Relative turns in probe priority order, 2 bits each starting at the LSB:
  // right (+1), front (+0), left (+3), back (+2).
  localparam logic [7:0] TURNS = {2'd2, 2'd3, 2'd0, 2'd1};

  state_t            state;
  logic [255:0]      maze_q;
  logic [3:0]        start_x_q;
  logic [3:0]        start_y_q;
  logic [3:0]        goal_x_q;
  logic [3:0]        goal_y_q;
  logic              busy;
  logic              done;
  logic              found;
  logic [3:0]        curr_x;
  logic [3:0]        curr_y;
  logic [1:0]        heading;
  logic [STEP_W-1:0] step_count;
  logic [255:0]      path_data;

  logic              next_ok;
  logic [1:0]        next_dir;
  logic [7:0]        next_cell;
  logic [8:0]        cand;

  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.found      = found;
  assign bus.curr_x     = curr_x;
  assign bus.curr_y     = curr_y;
  assign bus.heading    = heading;
  assign bus.step_count = step_count;
  assign bus.path_data  = path_data;

  // Neighbour of (x,y) in direction d, as {in_range, y, x}. The arithmetic is
  // 5 bits wide so that both -1 and 16 land with bit 4 set, which marks the
  // neighbour as outside the grid (no wrap-around).
  function automatic logic [8:0] step_cell(input logic [3:0] x,
                                           input logic [3:0] y,
                                           input logic [1:0] d);
    logic [4:0] nx;
    logic [4:0] ny;
    nx = {1'b0, x};
    ny = {1'b0, y};
    case (d)
      2'd0:    ny = ny - 5'd1;
      2'd1:    nx = nx + 5'd1;
      2'd2:    ny = ny + 5'd1;
      default: nx = nx - 5'd1;
    endcase
    return {~(nx[4] | ny[4]), ny[3:0], nx[3:0]};
  endfunction

  // Probe the four relative directions from lowest to highest priority so
  // the highest-priority open neighbour is the one left standing.
  always_comb begin
    next_ok   = 1'b0;
    next_dir  = heading;
    next_cell = {curr_y, curr_x};
    cand      = '0;
    for (int k = 3; k >= 0; k--) begin
      cand = step_cell(curr_x, curr_y, heading + TURNS[2*k +: 2]);
      if (cand[8] && maze_q[cand[7:0]]) begin
        next_ok   = 1'b1;
        next_dir  = heading + TURNS[2*k +: 2];
        next_cell = cand[7:0];
      end
    end
  end

  // Main controller: all outputs are registered here alongside the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      maze_q     <= '0;
      start_x_q  <= '0;
      start_y_q  <= '0;
      goal_x_q   <= '0;
      goal_y_q   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      found      <= 1'b0;
      curr_x     <= '0;
      curr_y     <= '0;
      heading    <= START_HEADING;
      step_count <= '0;
      path_data  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state      <= CHECK;
            maze_q     <= bus.maze_data;
            start_x_q  <= bus.start_x;
            start_y_q  <= bus.start_y;
            goal_x_q   <= bus.goal_x;
            goal_y_q   <= bus.goal_y;
            busy       <= 1'b1;
            done       <= 1'b0;
            found      <= 1'b0;
            curr_x     <= bus.start_x;
            curr_y     <= bus.start_y;
            heading    <= START_HEADING;
            step_count <= '0;
            path_data  <= 256'd1 << {bus.start_y, bus.start_x};
          end
        end

        CHECK: begin
          if (!maze_q[{start_y_q, start_x_q}] || !maze_q[{goal_y_q, goal_x_q}]) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            found <= 1'b0;
          end else if ((start_x_q == goal_x_q) && (start_y_q == goal_y_q)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            found <= 1'b1;
          end else begin
            state <= WALK;
          end
        end

        WALK: begin
          if ((curr_x == goal_x_q) && (curr_y == goal_y_q)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            found <= 1'b1;
          end else if (step_count == MAX_CNT) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            found <= 1'b0;
          end else if (next_ok) begin
            curr_x               <= next_cell[3:0];
            curr_y               <= next_cell[7:4];
            heading              <= next_dir;
            step_count           <= step_count + 1'b1;
            path_data[next_cell] <= 1'b1;
          end else begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            found <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
